// File: rtl/baw_game_ctrl.sv
// Black-and-White card game controller.
// NCARDS cards per hand, lead/follow turns, early finish at WIN_TARGET.
module baw_game_ctrl #(
  parameter int NCARDS     = 9,
  parameter int WIN_TARGET = 5,
  parameter int CW         = $clog2(NCARDS + 1)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              confirm,
  input  logic              clear,
  input  logic [NCARDS-1:0] sel,
  output logic [2:0]        state,
  output logic              turn,
  output logic [NCARDS-1:0] hand_p1,
  output logic [NCARDS-1:0] hand_p2,
  output logic [CW-1:0]     black_p1,
  output logic [CW-1:0]     white_p1,
  output logic [CW-1:0]     black_p2,
  output logic [CW-1:0]     white_p2,
  output logic              lead_black,
  output logic [CW-1:0]     round,
  output logic [CW-1:0]     score_p1,
  output logic [CW-1:0]     score_p2,
  output logic [1:0]        last_result,
  output logic [1:0]        game_result,
  output logic              err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEAD   = 3'd1;
  localparam logic [2:0] S_FOLLOW = 3'd2;
  localparam logic [2:0] S_RESULT = 3'd3;
  localparam logic [2:0] S_OVER   = 3'd4;

  localparam logic [CW-1:0] N_MAX = CW'(NCARDS);
  localparam logic [CW-1:0] WIN   = CW'(WIN_TARGET);
  localparam logic [CW-1:0] ONE   = CW'(1);

  logic              leader;
  logic [CW-1:0]     lead_val;
  logic [NCARDS-1:0] hand_act;
  logic              one_hot;
  logic              legal;
  logic [CW-1:0]     sel_val;
  logic [CW-1:0]     nb1, nw1, nb2, nw2;
  logic              end_game;

  assign hand_act = turn ? hand_p2 : hand_p1;
  assign one_hot  = (sel != '0) &&
                    ((sel & (sel - NCARDS'(1))) == '0);
  assign legal    = one_hot && ((sel & hand_act) != '0);
  assign end_game = (score_p1 == WIN) ||
                    (score_p2 == WIN) ||
                    (round == N_MAX);

  always_comb begin
    sel_val = '0;
    for (int k = 0; k < NCARDS; k++)
      if (sel[k]) sel_val = CW'(k);
  end

  // odd card values are black, even are white
  always_comb begin
    nb1 = '0;
    nw1 = '0;
    nb2 = '0;
    nw2 = '0;
    for (int k = 0; k < NCARDS; k++) begin
      if (k % 2 == 1) begin
        nb1 = nb1 + CW'(hand_p1[k]);
        nb2 = nb2 + CW'(hand_p2[k]);
      end else begin
        nw1 = nw1 + CW'(hand_p1[k]);
        nw2 = nw2 + CW'(hand_p2[k]);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      turn        <= 1'b0;
      leader      <= 1'b0;
      hand_p1     <= '0;
      hand_p2     <= '0;
      black_p1    <= '0;
      white_p1    <= '0;
      black_p2    <= '0;
      white_p2    <= '0;
      lead_black  <= 1'b0;
      lead_val    <= '0;
      round       <= '0;
      score_p1    <= '0;
      score_p2    <= '0;
      last_result <= 2'b00;
      game_result <= 2'b00;
      err         <= 1'b0;
    end else begin
      err      <= 1'b0;
      black_p1 <= nb1;
      white_p1 <= nw1;
      black_p2 <= nb2;
      white_p2 <= nw2;
      if (clear) begin
        if (state != S_IDLE) begin
          state       <= S_IDLE;
          turn        <= 1'b0;
          hand_p1     <= '0;
          hand_p2     <= '0;
          round       <= '0;
          score_p1    <= '0;
          score_p2    <= '0;
          last_result <= 2'b00;
          game_result <= 2'b00;
        end
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              state       <= S_LEAD;
              turn        <= 1'b0;
              leader      <= 1'b0;
              hand_p1     <= '1;
              hand_p2     <= '1;
              round       <= ONE;
              score_p1    <= '0;
              score_p2    <= '0;
              last_result <= 2'b00;
              game_result <= 2'b00;
            end
          end
          S_LEAD: begin
            if (confirm) begin
              if (legal) begin
                if (turn) hand_p2 <= hand_p2 & ~sel;
                else      hand_p1 <= hand_p1 & ~sel;
                lead_val   <= sel_val;
                lead_black <= sel_val[0];
                turn       <= ~turn;
                state      <= S_FOLLOW;
              end else begin
                err <= 1'b1;
              end
            end
          end
          S_FOLLOW: begin
            if (confirm) begin
              if (legal) begin
                if (turn) hand_p2 <= hand_p2 & ~sel;
                else      hand_p1 <= hand_p1 & ~sel;
                // winner of the round leads next; a tie keeps the leader
                if (sel_val != lead_val) begin
                  if ((sel_val > lead_val) == turn) begin
                    score_p2    <= score_p2 + ONE;
                    last_result <= 2'b10;
                    leader      <= 1'b1;
                  end else begin
                    score_p1    <= score_p1 + ONE;
                    last_result <= 2'b01;
                    leader      <= 1'b0;
                  end
                end else begin
                  last_result <= 2'b11;
                end
                state <= S_RESULT;
              end else begin
                err <= 1'b1;
              end
            end
          end
          S_RESULT: begin
            if (confirm) begin
              if (end_game) begin
                state <= S_OVER;
                if (score_p1 > score_p2)
                  game_result <= 2'b01;
                else if (score_p2 > score_p1)
                  game_result <= 2'b10;
                else
                  game_result <= 2'b11;
              end else begin
                round <= round + ONE;
                turn  <= leader;
                state <= S_LEAD;
              end
            end
          end
          S_OVER: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_baw_game_ctrl.sv
// Scoreboard bench for baw_game_ctrl.
// Two instances: 9 cards/target 5 and 4 cards/target 4.
module tb_baw_game_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;
  logic st0, cf0, cl0;
  logic st1, cf1, cl1;
  logic [8:0] sel0;
  logic [3:0] sel1;

  logic [2:0] a_state, b_state;
  logic a_turn, b_turn;
  logic [8:0] a_h1, a_h2;
  logic [3:0] b_h1, b_h2;
  logic [3:0] a_bk1, a_wt1, a_bk2, a_wt2;
  logic [2:0] b_bk1, b_wt1, b_bk2, b_wt2;
  logic a_lb, b_lb;
  logic [3:0] a_rd, a_s1, a_s2;
  logic [2:0] b_rd, b_s1, b_s2;
  logic [1:0] a_lr, a_gr, b_lr, b_gr;
  logic a_err, b_err;

  baw_game_ctrl #(.NCARDS(9), .WIN_TARGET(5)) dut0 (
    .clk(clk), .resetn(resetn), .start(st0),
    .confirm(cf0), .clear(cl0), .sel(sel0),
    .state(a_state), .turn(a_turn),
    .hand_p1(a_h1), .hand_p2(a_h2),
    .black_p1(a_bk1), .white_p1(a_wt1),
    .black_p2(a_bk2), .white_p2(a_wt2),
    .lead_black(a_lb), .round(a_rd),
    .score_p1(a_s1), .score_p2(a_s2),
    .last_result(a_lr), .game_result(a_gr),
    .err(a_err)
  );

  baw_game_ctrl #(.NCARDS(4), .WIN_TARGET(4)) dut1 (
    .clk(clk), .resetn(resetn), .start(st1),
    .confirm(cf1), .clear(cl1), .sel(sel1),
    .state(b_state), .turn(b_turn),
    .hand_p1(b_h1), .hand_p2(b_h2),
    .black_p1(b_bk1), .white_p1(b_wt1),
    .black_p2(b_bk2), .white_p2(b_wt2),
    .lead_black(b_lb), .round(b_rd),
    .score_p1(b_s1), .score_p2(b_s2),
    .last_result(b_lr), .game_result(b_gr),
    .err(b_err)
  );

  localparam int F_ST = 0, F_TN = 1, F_H1 = 2, F_H2 = 3;
  localparam int F_B1 = 4, F_W1 = 5, F_B2 = 6, F_W2 = 7;
  localparam int F_LB = 8, F_RD = 9, F_S1 = 10, F_S2 = 11;
  localparam int F_LR = 12, F_GR = 13, F_ER = 14;

  typedef struct {
    int    tag;
    int    dut;
    int    fld;
    int    val;
    string nm;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int mon_act;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int get(int d, int f);
    int r;
    r = 0;
    case (f)
      F_ST: r = d ? int'(b_state) : int'(a_state);
      F_TN: r = d ? int'(b_turn)  : int'(a_turn);
      F_H1: r = d ? int'(b_h1)    : int'(a_h1);
      F_H2: r = d ? int'(b_h2)    : int'(a_h2);
      F_B1: r = d ? int'(b_bk1)   : int'(a_bk1);
      F_W1: r = d ? int'(b_wt1)   : int'(a_wt1);
      F_B2: r = d ? int'(b_bk2)   : int'(a_bk2);
      F_W2: r = d ? int'(b_wt2)   : int'(a_wt2);
      F_LB: r = d ? int'(b_lb)    : int'(a_lb);
      F_RD: r = d ? int'(b_rd)    : int'(a_rd);
      F_S1: r = d ? int'(b_s1)    : int'(a_s1);
      F_S2: r = d ? int'(b_s2)    : int'(a_s2);
      F_LR: r = d ? int'(b_lr)    : int'(a_lr);
      F_GR: r = d ? int'(b_gr)    : int'(a_gr);
      F_ER: r = d ? int'(b_err)   : int'(a_err);
      default: r = -1;
    endcase
    return r;
  endfunction

  // monitor: compare every entry due this cycle
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].tag <= cyc) begin
        checks = checks + 1;
        mon_act = get(q[i].dut, q[i].fld);
        if (q[i].tag < cyc) begin
          failures = failures + 1;
          $display("FAIL %s dut%0d: stale entry", q[i].nm, q[i].dut);
        end else if (mon_act != q[i].val) begin
          failures = failures + 1;
          $display("FAIL %s dut%0d: got %0d expected %0d",
                   q[i].nm, q[i].dut, mon_act, q[i].val);
        end
        q.delete(i);
      end
    end
  end

  task automatic ex(int d, int f, int v, string nm, int lag = 0);
    exp_t e;
    e.tag = cyc + lag;
    e.dut = d;
    e.fld = f;
    e.val = v;
    e.nm  = nm;
    q.push_back(e);
  endtask

  task automatic drive(int d, bit s, bit c, bit k, int mask);
    if (d == 0) begin
      st0 = s; cf0 = c; cl0 = k; sel0 = 9'(mask);
    end else begin
      st1 = s; cf1 = c; cl1 = k; sel1 = 4'(mask);
    end
    @(posedge clk);
    #1;
    st0 = 0; cf0 = 0; cl0 = 0;
    st1 = 0; cf1 = 0; cl1 = 0;
  endtask

  task automatic play(int d, int card);
    drive(d, 0, 1, 0, 1 << card);
  endtask

  task automatic adv(int d);
    drive(d, 0, 1, 0, 0);
  endtask

  task automatic startg(int d);
    drive(d, 1, 0, 0, 0);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    resetn = 0;
    st0 = 0; cf0 = 0; cl0 = 0; sel0 = '0;
    st1 = 0; cf1 = 0; cl1 = 0; sel1 = '0;
    @(posedge clk);
    #1;
    for (int f = 0; f < 15; f++)
      ex(0, f, 0, $sformatf("rst_f%0d", f));
    ex(1, F_ST, 0, "rst_state");
    @(posedge clk);
    #1;
    resetn = 1;
    idle(1);

    // reset during FOLLOW with score_p1=2
    startg(0);
    ex(0, F_ST, 1, "start_lead");
    ex(0, F_RD, 1, "start_round");
    ex(0, F_H1, 'h1FF, "start_hand");
    play(0, 8); play(0, 0); adv(0);
    play(0, 7); play(0, 1); adv(0);
    play(0, 6);
    ex(0, F_S1, 2, "pre_rst_s1");
    ex(0, F_ST, 2, "pre_rst_follow");
    ex(0, F_RD, 3, "pre_rst_round");
    ex(0, F_TN, 1, "pre_rst_turn");
    idle(1);
    resetn = 0;
    for (int f = 0; f < 15; f++)
      ex(0, f, 0, $sformatf("midrst_f%0d", f));
    @(posedge clk);
    #1;
    resetn = 1;
    ex(0, F_ST, 0, "post_rst_idle");
    idle(1);

    // P1 leads 8, P2 follows 3
    startg(0);
    play(0, 8);
    ex(0, F_ST, 2, "lead_follow");
    ex(0, F_TN, 1, "lead_turn");
    ex(0, F_H1, 'h0FF, "lead_hand1");
    ex(0, F_LB, 0, "lead_white");
    ex(0, F_W1, 5, "w1_lag");
    play(0, 3);
    ex(0, F_ST, 3, "fol_result");
    ex(0, F_LR, 1, "fol_lr");
    ex(0, F_S1, 1, "fol_s1");
    ex(0, F_S2, 0, "fol_s2");
    ex(0, F_H2, 'h1F7, "fol_hand2");
    ex(0, F_W1, 4, "fol_w1");
    ex(0, F_B1, 4, "fol_b1");
    ex(0, F_B2, 4, "b2_lag");
    ex(0, F_B2, 3, "b2_new", 1);
    ex(0, F_W2, 5, "w2_new", 1);
    idle(1);
    adv(0);
    ex(0, F_ST, 1, "r2_lead");
    ex(0, F_TN, 0, "r2_leader_p1");
    ex(0, F_RD, 2, "r2_round");

    // illegal selections
    drive(0, 0, 1, 0, 'b11);
    ex(0, F_ER, 1, "err_twohot");
    ex(0, F_ST, 1, "err_th_state");
    ex(0, F_H1, 'h0FF, "err_th_hand");
    ex(0, F_ER, 0, "err_th_pulse", 1);
    idle(1);
    play(0, 8);
    ex(0, F_ER, 1, "err_played");
    ex(0, F_ST, 1, "err_pl_state");
    ex(0, F_H1, 'h0FF, "err_pl_hand");
    ex(0, F_S1, 1, "err_pl_s1");
    ex(0, F_ER, 0, "err_pl_pulse", 1);
    idle(1);

    // tie
    play(0, 5);
    ex(0, F_LB, 1, "tie_black");
    play(0, 5);
    ex(0, F_ST, 3, "tie_result");
    ex(0, F_LR, 3, "tie_lr");
    ex(0, F_S1, 1, "tie_s1");
    ex(0, F_S2, 0, "tie_s2");
    ex(0, F_H2, 'h1D7, "tie_hand2");
    adv(0);
    ex(0, F_ST, 1, "tie_lead");
    ex(0, F_TN, 0, "tie_same_leader");
    ex(0, F_RD, 3, "tie_round");

    drive(0, 0, 0, 1, 0);
    ex(0, F_ST, 0, "clr_idle");
    ex(0, F_RD, 0, "clr_round");
    ex(0, F_S1, 0, "clr_s1");
    ex(0, F_H1, 0, "clr_h1");
    ex(0, F_H2, 0, "clr_h2");
    ex(0, F_LR, 0, "clr_lr");
    adv(0);
    ex(0, F_ER, 0, "idle_cf_noerr");
    ex(0, F_ST, 0, "idle_cf_state");

    // P2 wins five straight rounds
    startg(0);
    play(0, 0); play(0, 1);
    ex(0, F_LR, 2, "p2_lr");
    ex(0, F_S2, 1, "p2_s2");
    adv(0);
    ex(0, F_TN, 1, "p2_leads");
    ex(0, F_RD, 2, "p2_round2");
    play(0, 2);
    ex(0, F_TN, 0, "p1_follows");
    play(0, 1); adv(0);
    play(0, 3); play(0, 2); adv(0);
    play(0, 4); play(0, 3); adv(0);
    play(0, 5); play(0, 4);
    ex(0, F_S2, 5, "p2_s2_final");
    ex(0, F_S1, 0, "p2_s1_final");
    ex(0, F_ST, 3, "p2_result");
    adv(0);
    ex(0, F_ST, 4, "p2_over");
    ex(0, F_GR, 2, "p2_gr");
    ex(0, F_RD, 5, "p2_round5");
    play(0, 6);
    ex(0, F_ER, 0, "over_cf_noerr");
    ex(0, F_ST, 4, "over_cf_hold");
    startg(0);
    ex(0, F_ST, 4, "over_start_hold");

    // 4-card draw at 2-2
    startg(1);
    ex(1, F_ST, 1, "d_start");
    ex(1, F_H1, 'hF, "d_hand");
    play(1, 3); play(1, 0);
    ex(1, F_LR, 1, "d_r1");
    adv(1);
    play(1, 0); play(1, 3);
    ex(1, F_LR, 2, "d_r2");
    adv(1);
    ex(1, F_TN, 1, "d_p2_leads");
    play(1, 2); play(1, 1);
    ex(1, F_S2, 2, "d_r3_s2");
    adv(1);
    play(1, 1); play(1, 2);
    ex(1, F_S1, 2, "d_s1");
    ex(1, F_S2, 2, "d_s2");
    ex(1, F_LR, 1, "d_r4");
    ex(1, F_H1, 0, "d_h1_empty");
    ex(1, F_H2, 0, "d_h2_empty");
    adv(1);
    ex(1, F_ST, 4, "d_over");
    ex(1, F_GR, 3, "d_draw");
    ex(1, F_RD, 4, "d_round4");
    drive(1, 0, 1, 1, 1);
    ex(1, F_ST, 0, "d_clr_idle");
    ex(1, F_RD, 0, "d_clr_round");
    ex(1, F_S1, 0, "d_clr_s1");
    ex(1, F_ER, 0, "d_clr_noerr");

    idle(3);
    while (q.size() > 0) begin
      checks = checks + 1;
      failures = failures + 1;
      $display("FAIL %s dut%0d: never checked", q[0].nm, q[0].dut);
      q.delete(0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
